pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard controller for the five-stage RV32 pipeline (fetch/decode/execute/memory/writeback).
- Produces the operand-forwarding selects, the load-use stall, branch flushes, and multi-cycle memory-latency stalls.
- Keeps saturating performance counters.
- Sits beside the stage units in the processor top and drives their stall/flush enables and the execute-stage operand muxes.

---
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage RV32 pipeline.
// It provides the execute-stage operand forwarding selects, the load-use stall,
// the branch flush and the memory-latency stall.
// It also keeps saturating performance counters.
//
// Handshake note: this block has no valid/ready interfaces. Every stall/flush
// output is a level valid for the current cycle only. Stage registers sample it
// on the same rising edge as the data it governs.
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic [REG_AW-1:0] rdM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemReqM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              RegWriteW,
    input  logic              PCsrcM,
    input  logic              clr_cnt,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        FwdAE,
    output logic [1:0]        FwdBE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  lu_cnt,
    output logic              mem_wait
);

    // Width of the wait down-counter, and the value loaded on entry to WAIT.
    localparam int              CW     = $clog2(MEM_LAT) + 1;
    localparam bit              MULTI  = (MEM_LAT > 1);
    localparam int              LOAD_I = MULTI ? (MEM_LAT - 2) : 0;
    localparam logic [CW-1:0]   LOAD   = CW'(LOAD_I);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          mem_stall;
    logic          lu;
    logic          br;

    // Forwarding select for one execute-stage source operand.
    // The memory stage wins over writeback because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (RegWriteM && !MemtoRegM && (rdM != '0) && (rdM == rs)) begin
            sel = 2'b10;
        end else if (RegWriteW && (rdW != '0) && (rdW == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Operand forwarding selects and load-use detection, both purely combinational.
    always_comb begin
        FwdAE = fwd_sel(rs1E);
        FwdBE = fwd_sel(rs2E);
        lu    = RegWriteE && MemtoRegE && (rdE != '0) &&
                ((rdE == rs1D) || (rdE == rs2D));
    end

    // Memory-latency FSM state register.
    // Reset drops any wait in progress immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Memory-latency FSM next state and stall request.
    // The last WAIT cycle does not stall, so each access costs MEM_LAT-1 stall cycles.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        mem_stall = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemReqM && MULTI) begin
                    mem_stall = 1'b1;
                    state_nx  = S_WAIT;
                    cnt_nx    = LOAD;
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    mem_stall = 1'b1;
                    cnt_nx    = cnt - CW'(1);
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Stall/flush outputs.
    // A memory stall holds everything, including a resolved branch: PCsrcM stays
    // asserted while the memory stage is held, so the flush happens on release.
    // A branch beats load-use: the younger instructions are discarded anyway.
    always_comb begin
        br       = PCsrcM && !mem_stall;
        StallM   = mem_stall;
        StallE   = mem_stall;
        StallF   = mem_stall || (lu && !br);
        StallD   = mem_stall || (lu && !br);
        FlushD   = br;
        FlushE   = br || (lu && !mem_stall);
        FlushW   = mem_stall;
        mem_wait = (state == S_WAIT);
    end

    // Saturating performance counters; a clear takes precedence over an increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (StallF && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (lu && !br && !mem_stall && (lu_cnt != CNT_MAX)) begin
                lu_cnt <= lu_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Three instances share one set of inputs:
//   a_*: MEM_LAT=1, CNT_W=32
//   b_*: MEM_LAT=3, CNT_W=32
//   c_*: MEM_LAT=1, CNT_W=2 (used to exercise counter saturation)
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, MemReqM;
    logic       RegWriteW, PCsrcM, clr_cnt;

    logic        a_stall_f, a_stall_d, a_stall_e, a_stall_m;
    logic        a_flush_d, a_flush_e, a_flush_w, a_mem_wait;
    logic [1:0]  a_fwd_a, a_fwd_b;
    logic [31:0] a_stall_cnt, a_flush_cnt, a_lu_cnt;

    logic        b_stall_f, b_stall_d, b_stall_e, b_stall_m;
    logic        b_flush_d, b_flush_e, b_flush_w, b_mem_wait;
    logic [1:0]  b_fwd_a, b_fwd_b;
    logic [31:0] b_stall_cnt, b_flush_cnt, b_lu_cnt;

    logic        c_stall_f, c_stall_d, c_stall_e, c_stall_m;
    logic        c_flush_d, c_flush_e, c_flush_w, c_mem_wait;
    logic [1:0]  c_fwd_a, c_fwd_b;
    logic [1:0]  c_stall_cnt, c_flush_cnt, c_lu_cnt;

    int n_checks;
    int n_fail;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .rdM(rdM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemReqM(MemReqM), .rdW(rdW),
        .RegWriteW(RegWriteW), .PCsrcM(PCsrcM), .clr_cnt(clr_cnt),
        .StallF(a_stall_f), .StallD(a_stall_d), .StallE(a_stall_e), .StallM(a_stall_m),
        .FlushD(a_flush_d), .FlushE(a_flush_e), .FlushW(a_flush_w),
        .FwdAE(a_fwd_a), .FwdBE(a_fwd_b),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .lu_cnt(a_lu_cnt),
        .mem_wait(a_mem_wait)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(3), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .rdM(rdM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemReqM(MemReqM), .rdW(rdW),
        .RegWriteW(RegWriteW), .PCsrcM(PCsrcM), .clr_cnt(clr_cnt),
        .StallF(b_stall_f), .StallD(b_stall_d), .StallE(b_stall_e), .StallM(b_stall_m),
        .FlushD(b_flush_d), .FlushE(b_flush_e), .FlushW(b_flush_w),
        .FwdAE(b_fwd_a), .FwdBE(b_fwd_b),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .lu_cnt(b_lu_cnt),
        .mem_wait(b_mem_wait)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .rdM(rdM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemReqM(MemReqM), .rdW(rdW),
        .RegWriteW(RegWriteW), .PCsrcM(PCsrcM), .clr_cnt(clr_cnt),
        .StallF(c_stall_f), .StallD(c_stall_d), .StallE(c_stall_e), .StallM(c_stall_m),
        .FlushD(c_flush_d), .FlushE(c_flush_e), .FlushW(c_flush_w),
        .FwdAE(c_fwd_a), .FwdBE(c_fwd_b),
        .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt), .lu_cnt(c_lu_cnt),
        .mem_wait(c_mem_wait)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
        RegWriteE = 1'b0; MemtoRegE = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0;
        MemReqM = 1'b0; RegWriteW = 1'b0; PCsrcM = 1'b0; clr_cnt = 1'b0;
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        rdE = 5'd7; RegWriteE = 1'b1; MemtoRegE = 1'b1; rs2D = 5'd7;
    endtask

    // Check the memory-stall group on the MEM_LAT=3 instance.
    task automatic check_b_stall(input string tag, input logic exp);
        check_eq({tag, "_stall_m"}, 32'(b_stall_m), 32'(exp));
        check_eq({tag, "_stall_f"}, 32'(b_stall_f), 32'(exp));
        check_eq({tag, "_flush_w"}, 32'(b_flush_w), 32'(exp));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clear_inputs();

        // Reset state
        #3;
        check_eq("rst_stall_f", 32'(a_stall_f), 0);
        check_eq("rst_flush_e", 32'(a_flush_e), 0);
        check_eq("rst_fwd_a",   32'(a_fwd_a),   0);
        check_eq("rst_b_stall_m", 32'(b_stall_m), 0);
        check_eq("rst_stall_cnt", a_stall_cnt, 0);
        check_eq("rst_c_lu_cnt", 32'(c_lu_cnt), 0);
        tick();
        rst = 1'b1;
        tick();

        // Forwarding
        rdM = 5'd5; rdW = 5'd5; rs1E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        check_eq("fwd_a_mem", 32'(a_fwd_a), 2);
        check_eq("fwd_b_none", 32'(a_fwd_b), 0);
        rs2E = 5'd5;
        #1;
        check_eq("fwd_b_mem", 32'(a_fwd_b), 2);
        MemtoRegM = 1'b1;
        #1;
        check_eq("fwd_a_load_in_m", 32'(a_fwd_a), 1);
        MemtoRegM = 1'b0; RegWriteM = 1'b0;
        #1;
        check_eq("fwd_a_wb", 32'(a_fwd_a), 1);
        rs1E = 5'd0;
        #1;
        check_eq("fwd_a_x0", 32'(a_fwd_a), 0);
        check_eq("fwd_b_wb", 32'(a_fwd_b), 1);
        clear_inputs();
        tick();

        // Load-use
        set_load_use();
        #1;
        check_eq("lu_stall_f", 32'(a_stall_f), 1);
        check_eq("lu_stall_d", 32'(a_stall_d), 1);
        check_eq("lu_flush_e", 32'(a_flush_e), 1);
        check_eq("lu_flush_d", 32'(a_flush_d), 0);
        check_eq("lu_stall_e", 32'(a_stall_e), 0);
        tick();
        clear_inputs();
        #1;
        check_eq("lu_lu_cnt",    a_lu_cnt,    1);
        check_eq("lu_stall_cnt", a_stall_cnt, 1);
        check_eq("lu_flush_cnt", a_flush_cnt, 0);
        check_eq("lu_idle_stall_f", 32'(a_stall_f), 0);
        tick();

        // Branch beats load-use
        set_load_use();
        PCsrcM = 1'b1;
        #1;
        check_eq("br_flush_d", 32'(a_flush_d), 1);
        check_eq("br_flush_e", 32'(a_flush_e), 1);
        check_eq("br_stall_f", 32'(a_stall_f), 0);
        check_eq("br_stall_d", 32'(a_stall_d), 0);
        tick();
        clear_inputs();
        #1;
        check_eq("br_flush_cnt", a_flush_cnt, 1);
        check_eq("br_lu_cnt",    a_lu_cnt,    1);
        check_eq("br_stall_cnt", a_stall_cnt, 1);

        // Synchronous clear
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        #1;
        check_eq("clr_a_stall_cnt", a_stall_cnt, 0);
        check_eq("clr_a_flush_cnt", a_flush_cnt, 0);
        check_eq("clr_a_lu_cnt",    a_lu_cnt,    0);
        check_eq("clr_b_stall_cnt", b_stall_cnt, 0);

        // MEM_LAT=3: two accesses back to back, MemReqM held high
        MemReqM = 1'b1;
        #1;
        check_b_stall("ml_t0", 1'b1);
        check_eq("ml_t0_stall_e", 32'(b_stall_e), 1);
        check_eq("ml_t0_a_stall_m", 32'(a_stall_m), 0);
        tick();
        check_b_stall("ml_t1", 1'b1);
        check_eq("ml_t1_wait", 32'(b_mem_wait), 1);
        tick();
        check_b_stall("ml_t2", 1'b0);
        check_eq("ml_t2_stall_cnt", b_stall_cnt, 2);
        tick();
        check_b_stall("ml_t3", 1'b1);
        tick();
        check_b_stall("ml_t4", 1'b1);
        tick();
        check_b_stall("ml_t5", 1'b0);
        MemReqM = 1'b0;
        tick();
        check_eq("ml_b2b_stall_cnt", b_stall_cnt, 4);
        check_b_stall("ml_t6", 1'b0);

        // MEM_LAT=3: branch resolved while the memory stage is held
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        MemReqM = 1'b1;
        PCsrcM  = 1'b1;
        #1;
        check_eq("mb_t0_flush_d", 32'(b_flush_d), 0);
        check_eq("mb_t0_flush_e", 32'(b_flush_e), 0);
        check_eq("mb_t0_a_flush_d", 32'(a_flush_d), 1);
        tick();
        check_eq("mb_t1_flush_d", 32'(b_flush_d), 0);
        tick();
        check_eq("mb_t2_flush_d", 32'(b_flush_d), 1);
        check_eq("mb_t2_stall_m", 32'(b_stall_m), 0);
        tick();
        clear_inputs();
        #1;
        check_eq("mb_flush_cnt", b_flush_cnt, 1);

        // Reset in the middle of a wait
        MemReqM = 1'b1;
        tick();
        check_eq("rw_in_wait", 32'(b_mem_wait), 1);
        MemReqM = 1'b0;
        rst     = 1'b0;
        #1;
        check_eq("rw_wait_abort", 32'(b_mem_wait), 0);
        check_b_stall("rw_rst", 1'b0);
        check_eq("rw_b_stall_cnt", b_stall_cnt, 0);
        check_eq("rw_b_flush_cnt", b_flush_cnt, 0);
        tick();
        rst = 1'b1;
        tick();
        MemReqM = 1'b1;
        #1;
        check_b_stall("rw_r0", 1'b1);
        tick();
        check_b_stall("rw_r1", 1'b1);
        tick();
        check_b_stall("rw_r2", 1'b0);
        MemReqM = 1'b0;
        tick();
        check_eq("rw_restart_cnt", b_stall_cnt, 2);

        // Saturation on the 2-bit counters, then clear wins over increment
        set_load_use();
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        check_eq("sat_c_lu_cnt",    32'(c_lu_cnt),    3);
        check_eq("sat_c_stall_cnt", 32'(c_stall_cnt), 3);
        check_eq("sat_a_lu_cnt",    a_lu_cnt,         5);
        clr_cnt = 1'b1;
        tick();
        clear_inputs();
        #1;
        check_eq("clr_c_lu_cnt",    32'(c_lu_cnt),    0);
        check_eq("clr_c_stall_cnt", 32'(c_stall_cnt), 0);
        check_eq("clr_a_lu_cnt2",   a_lu_cnt,         0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
